// File: rtl/ysyx_23060201_lsu.sv
// Load/store unit: aligns execute-stage memory requests onto a word-wide
// valid/ready data bus and returns extended load data plus an error flag.
module ysyx_23060201_lsu #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic                  req_ren,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [7:0]            req_wmask,
   input  logic [7:0]            req_rmask,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   input  logic                  resp_ready,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  bus_valid,
   input  logic                  bus_ready,
   output logic                  bus_wen,
   output logic [ADDR_WIDTH-1:0] bus_addr,
   output logic [3:0]            bus_wstrb,
   output logic [DATA_WIDTH-1:0] bus_wdata,
   input  logic                  bus_rvalid,
   input  logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic                  bus_err
);

   localparam logic [7:0] TO = 8'(TIMEOUT);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [4:0]            mask_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic                  wen_q;
   logic [7:0]            cnt_q;
   logic [DATA_WIDTH-1:0] rdata_q;
   logic                  err_q;

   logic                  accept;
   logic [4:0]            req_mask;
   logic                  mask_ok, misalign, req_err, short_path;
   logic                  timed_out, sx;
   logic [DATA_WIDTH-1:0] shifted, load_data;
   logic                  unused_bits;

   // Upper mask bits carry no meaning; only [3:0] size and rmask[4] sign.
   assign unused_bits = ^{req_wmask[7:4], req_rmask[7:5]};

   assign accept     = req_valid && (state == IDLE);
   assign req_mask   = req_wen ? {1'b0, req_wmask[3:0]} : req_rmask[4:0];
   assign mask_ok    = (req_mask[3:0] == 4'b0001) || (req_mask[3:0] == 4'b0011) ||
                       (req_mask[3:0] == 4'b1111);
   assign misalign   = ((req_mask[3:0] == 4'b0011) && req_addr[0]) ||
                       ((req_mask[3:0] == 4'b1111) && (req_addr[1:0] != 2'b00));
   assign req_err    = (req_wen && req_ren) || !mask_ok || misalign;
   // No-op requests and all request-side errors answer without bus traffic.
   assign short_path = !(req_wen || req_ren) || req_err;

   assign timed_out  = (cnt_q == TO);
   assign shifted    = bus_rdata >> {addr_q[1:0], 3'b000};
   assign sx         = mask_q[4];

   always_comb begin
      load_data = shifted;
      case (mask_q[3:0])
         4'b0001: load_data = {{(DATA_WIDTH-8){sx & shifted[7]}}, shifted[7:0]};
         4'b0011: load_data = {{(DATA_WIDTH-16){sx & shifted[15]}}, shifted[15:0]};
         default: load_data = shifted;
      endcase
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: if (accept) state_nx = short_path ? RESP : REQ;
         REQ:  if (bus_ready) state_nx = WAIT;
         WAIT: if (bus_rvalid || timed_out) state_nx = RESP;
         RESP: if (resp_ready) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
      bus_valid  = 1'b0;
      bus_wen    = 1'b0;
      bus_addr   = '0;
      bus_wstrb  = 4'b0000;
      bus_wdata  = '0;
      if (state == REQ) begin
         bus_valid = 1'b1;
         bus_wen   = wen_q;
         bus_addr  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
         bus_wstrb = mask_q[3:0] << addr_q[1:0];
         bus_wdata = wdata_q << {addr_q[1:0], 3'b000};
      end
   end

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         addr_q  <= '0;
         mask_q  <= '0;
         wdata_q <= '0;
         wen_q   <= 1'b0;
         cnt_q   <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         state <= state_nx;
         case (state)
            IDLE: if (accept) begin
               addr_q  <= req_addr;
               mask_q  <= req_mask;
               wdata_q <= req_wdata;
               wen_q   <= req_wen;
               rdata_q <= '0;
               err_q   <= (req_wen || req_ren) && req_err;
            end
            REQ: cnt_q <= '0;
            WAIT: begin
               if (bus_rvalid) begin
                  err_q   <= bus_err;
                  rdata_q <= (bus_err || wen_q) ? '0 : load_data;
               end else if (timed_out) begin
                  err_q   <= 1'b1;
                  rdata_q <= '0;
               end else begin
                  cnt_q <= cnt_q + 8'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060201_lsu.sv
// Directed bench for ysyx_23060201_lsu; a monitor scores responses and bus
// requests against queues filled by the stimulus.
module tb_ysyx_23060201_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_wen, req_ren;
   logic [31:0] req_addr, req_wdata;
   logic [7:0]  req_wmask, req_rmask;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic        bus_valid, bus_ready, bus_wen, bus_rvalid, bus_err;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_wstrb;

   int cyc = 0;
   int acc_cyc = 0;
   int checks = 0;
   int errors = 0;

   typedef struct packed {logic [31:0] rdata; logic err;} resp_t;
   typedef struct packed {logic wen; logic [31:0] addr; logic [3:0] strb; logic [31:0] wdata;} bus_t;
   resp_t resp_q[$];
   bus_t  bus_q[$];

   ysyx_23060201_lsu dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen), .req_ren(req_ren),
      .req_addr(req_addr), .req_wmask(req_wmask), .req_rmask(req_rmask), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_wen(bus_wen), .bus_addr(bus_addr),
      .bus_wstrb(bus_wstrb), .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid),
      .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h want %h", name, act, exp);
      end
   endtask

   // Response / bus-request scoreboard
   always @(negedge clk) begin
      resp_t re;
      bus_t  be;
      if (resp_valid && resp_ready) begin
         if (resp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_resp got rdata %h err %0d want none", resp_rdata, resp_err);
         end else begin
            re = resp_q.pop_front();
            chk("resp_rdata", resp_rdata, re.rdata);
            chk("resp_err", 32'(resp_err), 32'(re.err));
         end
      end
      if (bus_valid && bus_ready) begin
         if (bus_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_bus_req got addr %h want none", bus_addr);
         end else begin
            be = bus_q.pop_front();
            chk("bus_wen", 32'(bus_wen), 32'(be.wen));
            chk("bus_addr", bus_addr, be.addr);
            chk("bus_wstrb", 32'(bus_wstrb), 32'(be.strb));
            chk("bus_wdata", bus_wdata, be.wdata);
         end
      end else if (bus_valid && bus_q.size() == 0) begin
         checks++; errors++;
         $display("FAIL unexpected_bus_valid got 1 want 0 addr %h", bus_addr);
      end
   end

   task automatic exp_bus(input logic wen, input logic [31:0] addr, input logic [3:0] strb,
                          input logic [31:0] wdata);
      bus_q.push_back('{wen: wen, addr: addr, strb: strb, wdata: wdata});
   endtask

   task automatic issue(input logic wen, input logic ren, input logic [31:0] addr,
                        input logic [7:0] wm, input logic [7:0] rm, input logic [31:0] wd,
                        input logic push, input logic [31:0] er, input logic ee);
      req_wen = wen; req_ren = ren; req_addr = addr;
      req_wmask = wm; req_rmask = rm; req_wdata = wd; req_valid = 1'b1;
      @(negedge clk);
      chk("req_ready_idle", 32'(req_ready), 32'd1);
      if (push) resp_q.push_back('{rdata: er, err: ee});
      @(posedge clk); #1;
      req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0;
      acc_cyc = cyc;
   endtask

   task automatic bus_serve(input int rd, input int rvd, input logic [31:0] rdata,
                            input logic berr, input logic no_rv, input logic [31:0] eaddr);
      for (int k = 0; k <= rd; k++) begin
         bus_ready = (k == rd);
         @(negedge clk);
         chk("bus_valid_hold", 32'(bus_valid), 32'd1);
         chk("bus_addr_hold", bus_addr, eaddr);
         @(posedge clk); #1;
      end
      bus_ready = 1'b0;
      repeat (rvd) begin @(posedge clk); #1; end
      if (!no_rv) begin
         bus_rvalid = 1'b1; bus_rdata = rdata; bus_err = berr;
         @(posedge clk); #1;
         bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
      end
   endtask

   task automatic wait_resp(input int lo, input int hi, input string name);
      int lat;
      lat = -1;
      for (int i = 0; i < 400; i++) begin
         @(negedge clk);
         if (resp_valid) begin
            lat = cyc - acc_cyc;
            break;
         end
      end
      checks++;
      if (lat < lo || lat > hi) begin
         errors++;
         $display("FAIL %s latency got %0d want %0d..%0d", name, lat, lo, hi);
      end
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0; req_ren = 1'b0;
      req_addr = '0; req_wmask = '0; req_rmask = '0; req_wdata = '0;
      resp_ready = 1'b1; bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0; bus_err = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_req_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_resp_err", 32'(resp_err), 32'd0);
      chk("rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
      chk("rst_bus_wdata", bus_wdata, 32'd0);
      step();

      // signed byte load, zero-wait bus
      exp_bus(1'b0, 32'h8000_0000, 4'h8, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0003, 8'h00, 8'h11, 32'h0, 1'b1, 32'hFFFF_FF85, 1'b0);
      bus_serve(0, 0, 32'h85FF_0000, 1'b0, 1'b0, 32'h8000_0000);
      wait_resp(2, 2, "sbyte"); step();

      // unsigned half load, bus_ready held low 3 cycles
      exp_bus(1'b0, 32'h8000_0000, 4'hC, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0002, 8'h00, 8'h03, 32'h0, 1'b1, 32'h0000_BEEF, 1'b0);
      bus_serve(3, 0, 32'hBEEF_1234, 1'b0, 1'b0, 32'h8000_0000);
      wait_resp(5, 5, "uhalf"); step();

      // signed half load
      exp_bus(1'b0, 32'h8000_0000, 4'hC, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0002, 8'h00, 8'h13, 32'h0, 1'b1, 32'hFFFF_BEEF, 1'b0);
      bus_serve(0, 0, 32'hBEEF_1234, 1'b0, 1'b0, 32'h8000_0000);
      wait_resp(2, 2, "shalf"); step();

      // byte store; ack carries junk data that must not leak
      exp_bus(1'b1, 32'h8000_0000, 4'h2, 32'h0000_AB00);
      issue(1'b1, 1'b0, 32'h8000_0001, 8'h01, 8'h00, 32'h0000_00AB, 1'b1, 32'h0, 1'b0);
      bus_serve(0, 1, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h8000_0000);
      wait_resp(3, 3, "sbstore"); step();

      // word load, delayed completion
      exp_bus(1'b0, 32'h8000_0004, 4'hF, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0004, 8'h00, 8'h0F, 32'h0, 1'b1, 32'h1234_5678, 1'b0);
      bus_serve(0, 2, 32'h1234_5678, 1'b0, 1'b0, 32'h8000_0004);
      wait_resp(4, 4, "lword"); step();

      // half and word stores
      exp_bus(1'b1, 32'h8000_0000, 4'hC, 32'hCAFE_0000);
      issue(1'b1, 1'b0, 32'h8000_0002, 8'h03, 8'h00, 32'h0000_CAFE, 1'b1, 32'h0, 1'b0);
      bus_serve(0, 0, 32'h0, 1'b0, 1'b0, 32'h8000_0000);
      wait_resp(2, 2, "shstore"); step();
      exp_bus(1'b1, 32'h8000_0010, 4'hF, 32'h1122_3344);
      issue(1'b1, 1'b0, 32'h8000_0010, 8'h0F, 8'h00, 32'h1122_3344, 1'b1, 32'h0, 1'b0);
      bus_serve(0, 0, 32'h0, 1'b0, 1'b0, 32'h8000_0010);
      wait_resp(2, 2, "swstore"); step();

      // short-path responses, no bus traffic
      issue(1'b0, 1'b1, 32'h8000_0002, 8'h00, 8'h1F, 32'h0, 1'b1, 32'h0, 1'b1);
      wait_resp(0, 0, "misalign_word"); step();
      issue(1'b0, 1'b1, 32'h8000_0001, 8'h00, 8'h13, 32'h0, 1'b1, 32'h0, 1'b1);
      wait_resp(0, 0, "misalign_half"); step();
      issue(1'b0, 1'b1, 32'h8000_0000, 8'h00, 8'h07, 32'h0, 1'b1, 32'h0, 1'b1);
      wait_resp(0, 0, "bad_mask"); step();
      issue(1'b0, 1'b0, 32'h8000_0000, 8'h0F, 8'h0F, 32'h0, 1'b1, 32'h0, 1'b0);
      wait_resp(0, 0, "noop"); step();
      issue(1'b1, 1'b1, 32'h8000_0000, 8'h0F, 8'h0F, 32'h0, 1'b1, 32'h0, 1'b1);
      wait_resp(0, 0, "both"); step();
      issue(1'b1, 1'b0, 32'h8000_0003, 8'h0F, 8'h00, 32'h0, 1'b1, 32'h0, 1'b1);
      wait_resp(0, 0, "misalign_store"); step();

      // bus error on completion
      exp_bus(1'b0, 32'h8000_0008, 4'hF, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0008, 8'h00, 8'h0F, 32'h0, 1'b1, 32'h0, 1'b1);
      bus_serve(0, 0, 32'h5555_AAAA, 1'b1, 1'b0, 32'h8000_0008);
      wait_resp(2, 2, "bus_err"); step();

      // timeout
      exp_bus(1'b0, 32'h8000_000C, 4'hF, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_000C, 8'h00, 8'h0F, 32'h0, 1'b1, 32'h0, 1'b1);
      bus_serve(0, 0, 32'h0, 1'b0, 1'b1, 32'h8000_000C);
      wait_resp(255, 258, "timeout"); step();

      // response held while writeback stalls
      resp_ready = 1'b0;
      exp_bus(1'b0, 32'h8000_0000, 4'h3, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0000, 8'h00, 8'h13, 32'h0, 1'b1, 32'hFFFF_8001, 1'b0);
      bus_serve(0, 0, 32'h0000_8001, 1'b0, 1'b0, 32'h8000_0000);
      wait_resp(2, 2, "hold");
      repeat (5) begin
         @(negedge clk);
         chk("hold_resp_valid", 32'(resp_valid), 32'd1);
         chk("hold_resp_rdata", resp_rdata, 32'hFFFF_8001);
      end
      step();
      resp_ready = 1'b1;
      @(negedge clk);
      step();

      // reset while waiting for completion
      exp_bus(1'b0, 32'h8000_0000, 4'hF, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0000, 8'h00, 8'h0F, 32'h0, 1'b0, 32'h0, 1'b0);
      bus_serve(0, 0, 32'h0, 1'b0, 1'b1, 32'h8000_0000);
      rst = 1'b1;
      step();
      rst = 1'b0;
      @(negedge clk);
      chk("wait_rst_bus_valid", 32'(bus_valid), 32'd0);
      chk("wait_rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("wait_rst_req_ready", 32'(req_ready), 32'd1);
      step();
      bus_rvalid = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      step();
      bus_rvalid = 1'b0; bus_rdata = '0;
      @(negedge clk);
      chk("stray_rvalid_resp_valid", 32'(resp_valid), 32'd0);
      chk("stray_rvalid_req_ready", 32'(req_ready), 32'd1);
      step();

      // normal operation after reset
      exp_bus(1'b0, 32'h8000_0020, 4'hF, 32'h0);
      issue(1'b0, 1'b1, 32'h8000_0020, 8'h00, 8'h0F, 32'h0, 1'b1, 32'hCAFE_BABE, 1'b0);
      bus_serve(0, 0, 32'hCAFE_BABE, 1'b0, 1'b0, 32'h8000_0020);
      wait_resp(2, 2, "post_rst"); step();

      repeat (3) step();
      chk("resp_q_drained", 32'(resp_q.size()), 32'd0);
      chk("bus_q_drained", 32'(bus_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ysyx_23060201_lsu.md
Name: ysyx_23060201_lsu

Overview:
Load/store unit directly downstream of the execute stage. Consumes the execute stage's memory request (enable, address, mask, write data), performs byte-lane alignment and alignment checking, runs a valid/ready transaction on the data-memory bus, and returns sign- or zero-extended load data with an error flag. Sits between execute and the data-memory port; writeback takes the response.

Parameters:
ADDR_WIDTH, 32, address width
DATA_WIDTH, 32, data width (fixed at 32; 4 byte lanes)
TIMEOUT, 255, maximum WAIT cycles before a bus error is flagged (8-bit counter)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
req_valid  in  1  request from execute
req_ready  out  1  LSU can accept a request
req_wen  in  1  store
req_ren  in  1  load
req_addr  in  ADDR_WIDTH  byte address (rs1+imm)
req_wmask  in  8  store mask: 0x01 byte, 0x03 half, 0x0F word
req_rmask  in  8  load mask: bit4 = sign-extend, bits[3:0] as wmask
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  response available
resp_ready  in  1  writeback accepts response
resp_rdata  out  DATA_WIDTH  extended load data (0 for stores)
resp_err  out  1  misalignment, bad mask, or bus error/timeout
bus_valid  out  1  bus request
bus_ready  in  1  bus accepted request
bus_wen  out  1  write
bus_addr  out  ADDR_WIDTH  word-aligned address ({addr[31:2],2'b00})
bus_wstrb  out  4  byte strobes
bus_wdata  out  DATA_WIDTH  lane-shifted write data
bus_rvalid  in  1  completion (read data or write ack)
bus_rdata  in  DATA_WIDTH  read word
bus_err  in  1  error, sampled with bus_rvalid

Behaviour:
- Reset (synchronous, rst=1 at clk edge): state=IDLE; req_ready=1 after reset; resp_valid=0, resp_rdata=0, resp_err=0, bus_valid=0, bus_wen=0, bus_addr=0, bus_wstrb=0, bus_wdata=0, timeout counter=0. Reset mid-transaction abandons it; bus_valid low the following cycle; late bus_rvalid ignored in IDLE.
- States: IDLE, REQ, WAIT, RESP. req_ready=1 only in IDLE.
- IDLE: on req_valid&req_ready latch addr, masks, wdata, wen/ren. Next state:
  - ren=wen=0: RESP, rdata=0, err=0 (no bus traffic).
  - ren=wen=1: RESP, err=1.
  - mask[3:0] not in {0001,0011,1111}: RESP, err=1.
  - misaligned (half with addr[0]=1; word with addr[1:0]!=0): RESP, err=1, no bus traffic.
  - else REQ.
- REQ: bus_valid=1, bus_wen=latched wen, bus_addr word-aligned, bus_wstrb = wmask[3:0] << addr[1:0] (reads: rmask[3:0] << addr[1:0]), bus_wdata = wdata << (8*addr[1:0]). All held stable until bus_valid&bus_ready; then WAIT, counter cleared.
- WAIT: bus_valid=0. On bus_rvalid: latch result, go RESP, err=bus_err. Otherwise counter increments; when counter reaches TIMEOUT without rvalid: RESP, err=1, rdata=0. rvalid in same cycle as counter==TIMEOUT counts as completion.
- Read extraction: s = bus_rdata >> (8*addr[1:0]); byte: s[7:0], half: s[15:0], word: s. If rmask[4]=1 sign-extend from top kept bit, else zero-extend. Stores return rdata=0. Error responses return rdata=0.
- RESP: resp_valid=1, rdata/err stable until resp_valid&resp_ready; then IDLE (req_ready=1 next cycle). No new request accepted in the same cycle as response handshake.
- Latency: accept at cycle N, bus_valid at N+1; zero-wait bus (ready at N+1, rvalid at N+2) gives resp_valid at N+3. Error short-path: resp_valid at N+1.
- One outstanding transaction; no buffering.

Test Plan:
- Signed byte load: addr=0x80000003, rmask=0x11, bus_rdata=0x85FF_0000 -> bus_addr=0x80000000, bus_wstrb=0x8, resp_rdata=0xFFFFFF85, err=0, resp_valid 3 cycles after accept.
- Unsigned half load: addr=0x80000002, rmask=0x03, bus_rdata=0xBEEF1234 -> resp_rdata=0x0000BEEF; same with rmask=0x13 -> 0xFFFFBEEF.
- Byte store: addr=0x80000001, wmask=0x01, wdata=0x000000AB -> bus_wen=1, bus_wstrb=0x2, bus_wdata=0x0000AB00, resp_rdata=0, err=0.
- Misaligned word load addr=0x80000002, rmask=0x1F -> no bus_valid, resp_valid next cycle with err=1; bus_ready held low 3 cycles -> bus_valid and bus_addr stable throughout.
- Timeout: bus accepts, no rvalid for TIMEOUT=255 WAIT cycles -> resp_err=1, rdata=0; bus_err=1 with rvalid -> resp_err=1.
- Reset asserted in WAIT -> next cycle bus_valid=0, resp_valid=0, req_ready=1; stray rvalid then ignored; resp_ready held low 5 cycles -> resp_valid/rdata held.
